// File: rtl/regfile_mp_pkg.sv
// regfile_mp_pkg
//   Shared definitions for the multi-port register file slice:
//   - clear-sweep state encoding
//   - default geometry constants
//   - the zero word written by the sweep
//   - the field-slicing helper for flattened port vectors
package regfile_mp_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  localparam logic [DATA_W_DEF-1:0] ZERO_WORD = '0;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } rf_state_e;

  // Flattened port vectors carry port k of a w-bit field at [k*w +: w].
  function automatic int unsigned fld_lo(input int unsigned k, input int unsigned w);
    return k * w;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Pending-write scoreboard: one busy bit per register.
//   - A reservation sets the bit; a write clears it.
//   - If both hit the same register in one cycle, the set wins.
//   - Per read port, reports the busy bit of the addressed register.
// Ports:
//   clk, rst        clock, synchronous active-low reset (clears all busy bits)
//   en              file is operational; updates and lookups are gated by it
//   we/waddr        write ports (clear busy)
//   rsv_en/rsv_addr reservation port (set busy)
//   re/raddr        read ports
//   fwd             per read port: a same-cycle write is being forwarded
//   rbusy           per read port busy result
module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  input  logic [NUM_RD-1:0]        fwd,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DEPTH-1:0] busy;
  logic             rsv_ok;

  assign rsv_ok = rsv_en && !((ZERO_REG != 0) && (rsv_addr == '0));

  // Clears are issued before the set so the reservation overrides a
  // same-address write in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy <= '0;
    end else if (en) begin
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k]) begin
          busy[waddr[fld_lo(k, ADDR_W) +: ADDR_W]] <= 1'b0;
        end
      end
      if (rsv_ok) begin
        busy[rsv_addr] <= 1'b1;
      end
    end
  end

  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              is_zero;
    rbusy = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra       = raddr[fld_lo(i, ADDR_W) +: ADDR_W];
      is_zero  = (ZERO_REG != 0) && (ra == '0);
      rbusy[i] = en & re[i] & busy[ra] & ~fwd[i] & ~is_zero;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp
//   Parametrised multi-port integer register file.
//   - After reset, a hardware sweep clears every entry, then raises ready.
//   - A pending-write scoreboard supports hazard detection.
//   - Same-address writes resolve in favour of the higher port index.
// Ports:
//   clk              clock, rising edge
//   rst              synchronous reset, active-low
//   we/waddr/wdata   write ports (flattened, port k at [k*W +: W])
//   re/raddr         read ports (flattened)
//   rdata            combinational read data
//   rbusy            combinational pending-write bit of the addressed register
//   rsv_en/rsv_addr  destination reservation (marks register busy)
//   ready            clear sweep complete, file usable
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned NUM_WR   = 1,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD-1:0]        re,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     rsv_en,
  input  logic [ADDR_W-1:0]        rsv_addr,
  output logic                     ready
);

  localparam int unsigned       DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  rf_state_e         state;
  rf_state_e         state_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              active;
  logic [NUM_RD-1:0] fwd;

  // ---------------------------------------------------------------
  // Clear FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= ST_RESET;
    end else begin
      state <= state_nxt;
    end
  end

  // The first edge out of RESET already clears entry 0, so the sweep
  // spans exactly DEPTH edges and ready rises on the DEPTH-th one.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET, ST_CLEAR: state_nxt = (cnt == LAST) ? ST_READY : ST_CLEAR;
      ST_READY:           state_nxt = ST_READY;
      default:            state_nxt = ST_RESET;
    endcase
  end

  always_comb begin
    ready  = (state == ST_READY);
    active = rst & ready;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state != ST_READY) begin
      cnt <= cnt + ADDR_W'(1);
    end
  end

  // ---------------------------------------------------------------
  // Storage: sweep clear, then port writes (later port overrides)
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      if (state != ST_READY) begin
        mem[cnt] <= DATA_W'(ZERO_WORD);
      end else begin
        for (int unsigned k = 0; k < NUM_WR; k++) begin
          if (we[k] &&
              !((ZERO_REG != 0) && (waddr[fld_lo(k, ADDR_W) +: ADDR_W] == '0))) begin
            mem[waddr[fld_lo(k, ADDR_W) +: ADDR_W]] <= wdata[fld_lo(k, DATA_W) +: DATA_W];
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------
  // Read mux with write forwarding
  // ---------------------------------------------------------------
  always_comb begin
    logic [ADDR_W-1:0] ra;
    logic              hit;
    logic [DATA_W-1:0] bval;
    rdata = '0;
    fwd   = '0;
    for (int unsigned i = 0; i < NUM_RD; i++) begin
      ra   = raddr[fld_lo(i, ADDR_W) +: ADDR_W];
      hit  = 1'b0;
      bval = '0;
      // Ascending scan: the highest-index matching write port is kept.
      for (int unsigned k = 0; k < NUM_WR; k++) begin
        if (we[k] && (waddr[fld_lo(k, ADDR_W) +: ADDR_W] == ra)) begin
          hit  = 1'b1;
          bval = wdata[fld_lo(k, DATA_W) +: DATA_W];
        end
      end
      if (BYPASS == 0) begin
        hit = 1'b0;
      end
      if (active && re[i] && !((ZERO_REG != 0) && (ra == '0))) begin
        fwd[i] = hit;
        rdata[fld_lo(i, DATA_W) +: DATA_W] = hit ? bval : mem[ra];
      end
    end
  end

  // ---------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------
  regfile_scoreboard #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .NUM_WR   (NUM_WR),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .en       (active),
    .we       (we),
    .waddr    (waddr),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .re       (re),
    .raddr    (raddr),
    .fwd      (fwd),
    .rbusy    (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic [1:0]  re;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        ready;

  int errors = 0;
  int checks = 0;

  regfile_mp #(
    .DATA_W   (32),
    .ADDR_W   (5),
    .NUM_RD   (2),
    .NUM_WR   (2),
    .ZERO_REG (1),
    .BYPASS   (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .re       (re),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  // Reference model: architectural register contents, pending bits,
  // and the number of released edges seen since the last reset.
  logic [31:0] m_reg [32];
  bit          m_busy [32];
  int          m_since_rel;
  bit          m_ready;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(input int i);
    logic [4:0] a;
    a = raddr[i*5 +: 5];
    if (!(rst && m_ready) || !re[i] || a == 5'd0) return 32'h0;
    if (we[1] && waddr[9:5] == a) return wdata[63:32];
    if (we[0] && waddr[4:0] == a) return wdata[31:0];
    return m_reg[a];
  endfunction

  function automatic logic exp_rb(input int i);
    logic [4:0] a;
    a = raddr[i*5 +: 5];
    if (!(rst && m_ready) || !re[i] || a == 5'd0) return 1'b0;
    if ((we[1] && waddr[9:5] == a) || (we[0] && waddr[4:0] == a)) return 1'b0;
    return m_busy[a];
  endfunction

  task automatic model_edge();
    if (!rst) begin
      m_since_rel = 0;
      m_ready     = 0;
      for (int a = 0; a < 32; a++) m_busy[a] = 0;
    end else if (!m_ready) begin
      m_reg[m_since_rel] = 32'h0;
      m_since_rel++;
      if (m_since_rel == 32) m_ready = 1;
    end else begin
      if (we[0] && waddr[4:0] != 0) m_reg[waddr[4:0]] = wdata[31:0];
      if (we[1] && waddr[9:5] != 0) m_reg[waddr[9:5]] = wdata[63:32];
      if (we[0]) m_busy[waddr[4:0]] = 0;
      if (we[1]) m_busy[waddr[9:5]] = 0;
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1;
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic edge_step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_ready"}, {31'b0, ready}, {31'b0, m_ready});
    chk({tag, "_rd0"}, rdata[31:0], exp_rd(0));
    chk({tag, "_rd1"}, rdata[63:32], exp_rd(1));
    chk({tag, "_rb0"}, {31'b0, rbusy[0]}, {31'b0, exp_rb(0)});
    chk({tag, "_rb1"}, {31'b0, rbusy[1]}, {31'b0, exp_rb(1)});
  endtask

  task automatic tick(input string tag);
    settle();
    check_model(tag);
    edge_step();
  endtask

  task automatic idle_inputs();
    we = 2'b00; waddr = '0; wdata = '0;
    re = 2'b00; raddr = '0; rsv_en = 1'b0; rsv_addr = '0;
  endtask

  // Counts released edges until ready rises; bounded so a stuck sweep
  // still reaches the summary.
  task automatic measure_sweep(input string tag);
    int n;
    n = 0;
    while (!ready && n < 40) begin
      tick(tag);
      n++;
    end
    chk({tag, "_len"}, n, 32);
  endtask

  task automatic read_all_clear(input string tag);
    for (int a = 0; a < 16; a++) begin
      idle_inputs();
      re    = 2'b11;
      raddr = {5'(2*a + 1), 5'(2*a)};
      settle();
      chk({tag, "_rd0"}, rdata[31:0], 32'h0);
      chk({tag, "_rd1"}, rdata[63:32], 32'h0);
      chk({tag, "_rb"}, {30'b0, rbusy}, 32'h0);
      edge_step();
    end
  endtask

  typedef struct {
    logic [1:0]  we;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic [1:0]  re;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic        rsv;
    logic [4:0]  rsa;
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
    logic [1:0]  e_rb;
  } vec_t;

  vec_t tbl [17];

  initial begin
    tbl[0]  = '{2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,  2'b11, 5'd5,  5'd6,  1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
    tbl[1]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b01, 5'd5,  5'd0,  1'b0, 5'd0, 32'hDEADBEEF, 32'h0, 2'b00};
    tbl[2]  = '{2'b01, 5'd0,  32'h1234,     5'd0,  32'h0,  2'b11, 5'd0,  5'd0,  1'b0, 5'd0, 32'h0, 32'h0, 2'b00};
    tbl[3]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd0,  5'd0,  1'b0, 5'd0, 32'h0, 32'h0, 2'b00};
    tbl[4]  = '{2'b11, 5'd7,  32'h1,        5'd7,  32'h2,  2'b11, 5'd7,  5'd5,  1'b0, 5'd0, 32'h2, 32'hDEADBEEF, 2'b00};
    tbl[5]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b01, 5'd7,  5'd0,  1'b0, 5'd0, 32'h2, 32'h0, 2'b00};
    tbl[6]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd9,  5'd9,  1'b1, 5'd9, 32'h0, 32'h0, 2'b00};
    tbl[7]  = '{2'b01, 5'd9,  32'hAA,       5'd0,  32'h0,  2'b11, 5'd9,  5'd9,  1'b1, 5'd9, 32'hAA, 32'hAA, 2'b00};
    tbl[8]  = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd9,  5'd9,  1'b0, 5'd0, 32'hAA, 32'hAA, 2'b11};
    tbl[9]  = '{2'b10, 5'd0,  32'h0,        5'd9,  32'hBB, 2'b01, 5'd9,  5'd0,  1'b0, 5'd0, 32'hBB, 32'h0, 2'b00};
    tbl[10] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd9,  5'd9,  1'b0, 5'd0, 32'hBB, 32'hBB, 2'b00};
    tbl[11] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd0,  5'd7,  1'b1, 5'd0, 32'h0, 32'h2, 2'b00};
    tbl[12] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd0,  5'd7,  1'b1, 5'd3, 32'h0, 32'h2, 2'b00};
    tbl[13] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b10, 5'd3,  5'd3,  1'b0, 5'd0, 32'h0, 32'h0, 2'b10};
    tbl[14] = '{2'b11, 5'd0,  32'h5,        5'd0,  32'h6,  2'b11, 5'd0,  5'd0,  1'b0, 5'd0, 32'h0, 32'h0, 2'b00};
    tbl[15] = '{2'b11, 5'd10, 32'h10,       5'd11, 32'h11, 2'b11, 5'd10, 5'd11, 1'b0, 5'd0, 32'h10, 32'h11, 2'b00};
    tbl[16] = '{2'b00, 5'd0,  32'h0,        5'd0,  32'h0,  2'b11, 5'd10, 5'd11, 1'b0, 5'd0, 32'h10, 32'h11, 2'b00};

    m_ready = 0;
    m_since_rel = 0;
    for (int a = 0; a < 32; a++) m_busy[a] = 0;

    // Reset held for three cycles, then the sweep.
    rst = 1'b0;
    idle_inputs();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 3; c++) tick("reset");
    chk("reset_ready_low", {31'b0, ready}, 32'h0);
    rst = 1'b1;
    measure_sweep("sweep");
    chk("sweep_ready", {31'b0, ready}, 32'h1);
    read_all_clear("sweep_clear");

    // Directed vectors.
    for (int v = 0; v < 17; v++) begin
      we = tbl[v].we;   waddr = {tbl[v].wa1, tbl[v].wa0}; wdata = {tbl[v].wd1, tbl[v].wd0};
      re = tbl[v].re;   raddr = {tbl[v].ra1, tbl[v].ra0};
      rsv_en = tbl[v].rsv; rsv_addr = tbl[v].rsa;
      settle();
      chk($sformatf("vec%0d_rd0", v), rdata[31:0], tbl[v].e_rd0);
      chk($sformatf("vec%0d_rd1", v), rdata[63:32], tbl[v].e_rd1);
      chk($sformatf("vec%0d_rb", v), {30'b0, rbusy}, {30'b0, tbl[v].e_rb});
      edge_step();
    end

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 99) != 0);
      we       = 2'($urandom_range(0, 3));
      waddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wdata    = {$urandom, $urandom};
      re       = 2'($urandom_range(0, 3));
      raddr    = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      rsv_en   = ($urandom_range(0, 2) == 0);
      rsv_addr = 5'($urandom_range(0, 7));
      tick("rand");
    end

    // Make sure the file is ready and some bits are busy, then reset mid-sweep.
    idle_inputs();
    rst = 1'b1;
    if (!ready) measure_sweep("resweep");
    idle_inputs();
    we = 2'b01; waddr = {5'd0, 5'd4}; wdata = {32'h0, 32'h4444};
    rsv_en = 1'b1; rsv_addr = 5'd5;
    tick("pre_mid");
    idle_inputs();
    rsv_en = 1'b1; rsv_addr = 5'd6;
    tick("pre_mid");
    idle_inputs();
    re = 2'b11; raddr = {5'd6, 5'd5};
    settle();
    chk("pre_mid_busy", {30'b0, rbusy}, 32'h3);
    edge_step();

    idle_inputs();
    rst = 1'b0;
    tick("mid_rst");
    rst = 1'b1;
    for (int c = 0; c < 10; c++) tick("mid_sweep");
    chk("mid_ready_low", {31'b0, ready}, 32'h0);
    rst = 1'b0;
    tick("mid_rst2");
    rst = 1'b1;
    measure_sweep("mid_restart");
    read_all_clear("mid_clear");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
